// File: rtl/dsa_modadd_arbiter.sv
// dsa_modadd_arbiter: shares one modular adder between NREQ requesters.
// Round-robin grant, operand latching, adder enable sequencing, result return,
// and a watchdog that aborts operations whose adder never reports ready.
//
// state | meaning
// IDLE  | adder cleared (add_en=0), waiting for any request
// RUN   | adder enabled on latched operands, watchdog counting
// CLEAR | one cycle with add_en=0 to reset the adder; done/err visible here
module dsa_modadd_arbiter #(
  parameter int SIZE    = 256,
  parameter int NREQ    = 4,
  parameter int MAX_CYC = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*SIZE-1:0] req_a_i,
  input  logic [NREQ*SIZE-1:0] req_b_i,
  input  logic [NREQ*SIZE-1:0] req_p_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 err_o,
  output logic [SIZE-1:0]      res_o,
  output logic                 busy_o,
  output logic [SIZE-1:0]      add_a_o,
  output logic [SIZE-1:0]      add_b_o,
  output logic [SIZE-1:0]      add_p_o,
  output logic                 add_en_o,
  input  logic                 add_rdy_i,
  input  logic [SIZE-1:0]      add_c_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic [SIZE-1:0]   res_q, res_d;
  logic [SIZE-1:0]   add_a_q, add_a_d;
  logic [SIZE-1:0]   add_b_q, add_b_d;
  logic [SIZE-1:0]   add_p_q, add_p_d;

  logic [SIZE-1:0]   a_arr [NREQ];
  logic [SIZE-1:0]   b_arr [NREQ];
  logic [SIZE-1:0]   p_arr [NREQ];
  logic              found;
  logic [PW-1:0]     win_idx;

  // Unpack the flat operand buses so the winner can be selected by index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_i[g*SIZE +: SIZE];
    assign b_arr[g] = req_b_i[g*SIZE +: SIZE];
    assign p_arr[g] = req_p_i[g*SIZE +: SIZE];
  end

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin scan: first requester at or above ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[wrap_add(ptr_q, i)]) begin
        found   = 1'b1;
        win_idx = wrap_add(ptr_q, i);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    res_d   = res_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    add_p_d = add_p_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          add_a_d = a_arr[win_idx];
          add_b_d = b_arr[win_idx];
          add_p_d = p_arr[win_idx];
          gnt_d   = NREQ'(1) << win_idx;
          win_d   = win_idx;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // A ready adder takes precedence over a coinciding timeout.
        if (add_rdy_i) begin
          res_d   = add_c_i;
          done_d  = NREQ'(1) << win_q;
          state_d = CLEAR;
        end else if (cnt_q == CW'(MAX_CYC - 1)) begin
          res_d   = '0;
          done_d  = NREQ'(1) << win_q;
          err_d   = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        gnt_d   = '0;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      add_p_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      add_p_q <= add_p_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign res_o    = res_q;
  assign add_a_o  = add_a_q;
  assign add_b_o  = add_b_q;
  assign add_p_o  = add_p_q;
  assign add_en_o = (state_q == RUN);
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_dsa_modadd_arbiter.sv
// Directed bench for dsa_modadd_arbiter with a small behavioural modular adder.
module tb_dsa_modadd_arbiter;

  localparam int SIZE    = 16;
  localparam int NREQ    = 4;
  localparam int MAX_CYC = 16;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] req_a, req_b, req_p;
  logic [NREQ-1:0]      gnt, done;
  logic                 err, busy, add_en, add_rdy;
  logic [SIZE-1:0]      res, add_a, add_b, add_p, add_c;

  dsa_modadd_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .MAX_CYC(MAX_CYC)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .req_a_i  (req_a),
    .req_b_i  (req_b),
    .req_p_i  (req_p),
    .gnt_o    (gnt),
    .done_o   (done),
    .err_o    (err),
    .res_o    (res),
    .busy_o   (busy),
    .add_a_o  (add_a),
    .add_b_o  (add_b),
    .add_p_o  (add_p),
    .add_en_o (add_en),
    .add_rdy_i(add_rdy),
    .add_c_i  (add_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: ready two cycles after enable, never ready for p==0.
  logic [3:0]    lat;
  logic [SIZE:0] sum;
  always_ff @(posedge clk) begin
    if (!add_en) lat <= '0;
    else if (lat != 4'hF) lat <= lat + 4'd1;
  end
  assign sum     = {1'b0, add_a} + {1'b0, add_b};
  assign add_rdy = add_en && (lat >= 4'd2) && (add_p != '0);
  assign add_c   = (add_p == '0) ? '0 : SIZE'(sum % {1'b0, add_p});

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_op(input int i, input logic [SIZE-1:0] a, b, p);
    req_a[i*SIZE +: SIZE] = a;
    req_b[i*SIZE +: SIZE] = b;
    req_p[i*SIZE +: SIZE] = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a done pulse; also counts cycles with add_en high.
  task automatic wait_done(output logic [NREQ-1:0] d, output int runs);
    bit hit;
    hit  = 1'b0;
    d    = '0;
    runs = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (add_en) runs++;
      if (|done) begin
        d   = done;
        hit = 1'b1;
      end
    end
    if (!hit) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  logic [NREQ-1:0] d;
  int              runs;
  logic [NREQ-1:0] exp3 [4];

  initial begin
    rst   = 1'b1;
    req   = '0;
    req_a = '0;
    req_b = '0;
    req_p = '0;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res", res, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_en", add_en, 0);
    chk("rst_add_a", add_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single request, operands changed after grant
    set_op(1, 16'd5, 16'd9, 16'd11);
    req = 4'b0010;
    @(negedge clk);
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_add_a", add_a, 5);
    chk("t1_add_b", add_b, 9);
    chk("t1_add_p", add_p, 11);
    chk("t1_busy", busy, 1);
    chk("t1_add_en", add_en, 1);
    set_op(1, 16'd7, 16'd7, 16'd7);
    wait_done(d, runs);
    chk("t1_done", d, 4'b0010);
    chk("t1_res", res, 3);
    chk("t1_err", err, 0);
    chk("t1_add_en_clr", add_en, 0);
    chk("t1_gnt_clr", gnt, 4'b0010);
    chk("t1_add_a_held", add_a, 5);
    req = '0;
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_gnt_off", gnt, 0);
    chk("t1_busy_off", busy, 0);

    // 2: all request after reset, each drops at its own done
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, SIZE'(i + 1), 16'd2, 16'd11);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_done(d, runs);
      chk("t2_order", d, 32'd1 << k);
      chk("t2_res", res, k + 3);
      req = req & ~d;
    end
    req = '0;
    @(negedge clk);

    // 3: requesters 0 and 2 held continuously alternate
    do_reset();
    exp3[0] = 4'b0001; exp3[1] = 4'b0100; exp3[2] = 4'b0001; exp3[3] = 4'b0100;
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_done(d, runs);
      chk("t3_order", d, exp3[k]);
    end
    req = '0;
    @(negedge clk);

    // 4: watchdog abort on p==0, then a normal op
    set_op(3, 16'd4, 16'd5, 16'd0);
    req = 4'b1000;
    wait_done(d, runs);
    chk("t4_done", d, 4'b1000);
    chk("t4_err", err, 1);
    chk("t4_res", res, 0);
    chk("t4_run_cycles", runs, MAX_CYC);
    req = '0;
    @(negedge clk);
    chk("t4_add_en_after", add_en, 0);
    chk("t4_err_pulse", err, 0);
    chk("t4_done_pulse", done, 0);
    set_op(0, 16'd6, 16'd9, 16'd11);
    req = 4'b0001;
    wait_done(d, runs);
    chk("t4_next_done", d, 4'b0001);
    chk("t4_next_res", res, 4);
    chk("t4_next_err", err, 0);
    req = '0;
    @(negedge clk);

    // 5: asynchronous reset mid-RUN
    set_op(1, 16'd1, 16'd1, 16'd0);
    req = 4'b0010;
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_gnt", gnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_add_en", add_en, 0);
    chk("t5_add_b", add_b, 0);
    chk("t5_res", res, 0);
    chk("t5_done", done, 0);
    set_op(2, 16'd3, 16'd4, 16'd11);
    set_op(3, 16'd1, 16'd1, 16'd11);
    req = 4'b1100;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_add_en_rel", add_en, 0);
    @(negedge clk);
    chk("t5_first_gnt", gnt, 4'b0100);
    wait_done(d, runs);
    chk("t5_first_done", d, 4'b0100);
    chk("t5_first_res", res, 7);
    req = 4'b1000;
    wait_done(d, runs);
    chk("t5_second_done", d, 4'b1000);
    chk("t5_second_res", res, 2);
    req = '0;
    @(negedge clk);

    // 6: carry past bit SIZE, p = 2^SIZE-1
    set_op(0, 16'hFFFE, 16'hFFFE, 16'hFFFF);
    req = 4'b0001;
    wait_done(d, runs);
    chk("t6_done", d, 4'b0001);
    chk("t6_res", res, 16'hFFFD);
    chk("t6_err", err, 0);
    req = '0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
